// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract controller: drives a shared mpadder through two passes
// (raw op, then correction against the modulus) and selects the reduced result.
module mod_addsub_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             adder_start,
  output logic             adder_subtract,
  output logic [WIDTH-1:0] adder_in_a,
  output logic [WIDTH-1:0] adder_in_b,
  input  logic [WIDTH:0]   adder_result,
  input  logic             adder_done
);

  typedef enum logic [2:0] {
    IDLE, OP1_GO, OP1_WAIT, OP2_GO, OP2_WAIT, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   r1_q, r1_d, r2_q, r2_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             opsub_q, opsub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // adder_done is deliberately not looked at in the GO states: the stub/adder
  // may still hold done from the previous pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = OP1_GO;
      OP1_GO:   state_d = OP1_WAIT;
      OP1_WAIT: if (adder_done) state_d = OP2_GO;
      OP2_GO:   state_d = OP2_WAIT;
      OP2_WAIT: if (adder_done) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    adder_start    = (state_q == OP1_GO) || (state_q == OP2_GO);
    adder_subtract = opsub_q;
    adder_in_a     = opa_q;
    adder_in_b     = opb_q;
    result         = result_q;
    done           = done_q;
  end

  always_comb begin
    sub_d    = sub_q;
    m_d      = m_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opsub_d  = opsub_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sub_d   = subtract;
        m_d     = in_m;
        opa_d   = in_a;
        opb_d   = in_b;
        opsub_d = subtract;
      end
      // Correction pass: add M back after a subtract, try removing M after an add.
      OP1_WAIT: if (adder_done) begin
        r1_d    = adder_result;
        opa_d   = adder_result[WIDTH-1:0];
        opb_d   = m_q;
        opsub_d = ~sub_q;
      end
      OP2_WAIT: if (adder_done) r2_d = adder_result;
      FINISH: begin
        done_d = 1'b1;
        if (sub_q) result_d = r1_q[WIDTH] ? r2_q[WIDTH-1:0] : r1_q[WIDTH-1:0];
        else       result_d = r2_q[WIDTH] ? r1_q[WIDTH-1:0] : r2_q[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q    <= 1'b0;
      m_q      <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opsub_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      sub_q    <= sub_d;
      m_q      <= m_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opsub_q  <= opsub_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a fixed-latency mpadder stub (L=3,
// done held two cycles).
module tb_mod_addsub_ctrl;
  localparam int W = 16;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         reset, start, subtract;
  logic [W-1:0] in_a, in_b, in_m, result, adder_in_a, adder_in_b;
  logic         done, busy, adder_start, adder_subtract, adder_done;
  logic [W:0]   adder_result;

  int n_chk = 0, n_fail = 0;
  int n_done = 0, n_astart = 0, n_dd = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  mod_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .adder_start(adder_start), .adder_subtract(adder_subtract),
    .adder_in_a(adder_in_a), .adder_in_b(adder_in_b),
    .adder_result(adder_result), .adder_done(adder_done)
  );

  // mpadder stub: done visible L and L+1 cycles after the start pulse
  logic [L:0] sr = '0;
  logic [W:0] res_q = '0;
  always @(posedge clk) begin
    sr <= {sr[L-1:0], adder_start};
    if (adder_start)
      res_q <= adder_subtract ? ({1'b0, adder_in_a} - {1'b0, adder_in_b})
                              : ({1'b0, adder_in_a} + {1'b0, adder_in_b});
  end
  assign adder_done   = sr[L-1] | sr[L];
  assign adder_result = res_q;

  always @(posedge clk) begin
    if (done) n_done++;
    if (adder_start) n_astart++;
    if (done && done_prev) n_dd++;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] exp, input string tag, input int extra);
    int cyc;
    bit seen;
    in_a = a; in_b = b; subtract = s; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra);
      if (cyc == 1) begin in_a = '1; in_b = '1; subtract = ~s; end
      if (done) seen = 1;
    end
    start = 1'b0;
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(2 * L + 4));
    check({tag, "_res"}, 32'(result), 32'(exp));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a0, d0;
    reset = 1'b1; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = 16'd1000;
    repeat (3) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_astart", 32'(adder_start), 32'd0);
    check("rst_asub", 32'(adder_subtract), 32'd0);
    check("rst_ina", 32'(adder_in_a), 32'd0);
    check("rst_inb", 32'(adder_in_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(700, 500, 1'b0, 200, "add_700_500", -1);  repeat (2) @(negedge clk);
    do_op(100, 200, 1'b0, 300, "add_100_200", -1);  repeat (2) @(negedge clk);
    do_op(600, 400, 1'b0, 0,   "add_eq_m", -1);     repeat (2) @(negedge clk);
    do_op(300, 500, 1'b1, 800, "sub_300_500", -1);  repeat (2) @(negedge clk);
    do_op(500, 300, 1'b1, 200, "sub_500_300", -1);  repeat (2) @(negedge clk);
    do_op(999, 999, 1'b1, 0,   "sub_999_999", -1);  repeat (2) @(negedge clk);

    // second start while busy is dropped
    a0 = n_astart;
    do_op(123, 456, 1'b0, 579, "busy_ign", 2);
    check("busy_ign_astart", 32'(n_astart - a0), 32'd2);
    repeat (2) @(negedge clk);

    // reset during OP2_WAIT (cycle k+7)
    d0 = n_done; a0 = n_astart;
    in_a = 700; in_b = 500; subtract = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_astart", 32'(adder_start), 32'd0);
    check("mid_rst_ina", 32'(adder_in_a), 32'd0);
    check("mid_rst_inb", 32'(adder_in_b), 32'd0);
    check("mid_rst_asub", 32'(adder_subtract), 32'd0);
    repeat (4) @(negedge clk);
    check("mid_rst_nodone", 32'(n_done - d0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);
    check("mid_rst_astarts", 32'(n_astart - a0), 32'd2);
    do_op(1, 998, 1'b0, 999, "post_rst_add", -1);
    repeat (2) @(negedge clk);

    // back-to-back: second start lands in the done cycle
    a0 = n_astart;
    do_op(10, 20, 1'b1, 990, "b2b_first", -1);
    do_op(20, 10, 1'b1, 10,  "b2b_second", -1);
    check("b2b_astart", 32'(n_astart - a0), 32'd4);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clk);

    check("no_double_done", 32'(n_dd), 32'd0);
    check("total_done", 32'(n_done), 32'd10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
